// File: rtl/motor_drive.sv
// Two-wheel motor driver: registered mode decode, per-wheel ramp/reversal FSMs with
// drain and dead-time, and period-aligned PWM generation.

module motor_drive_wheel #(
    parameter int unsigned PWM_BITS    = 10,
    parameter int unsigned STEP        = 64,
    parameter int unsigned DEAD_CYCLES = 5000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [1:0]          tgt_dir,
    input  logic [PWM_BITS-1:0] tgt_duty,
    output logic [1:0]          dir,
    output logic [PWM_BITS-1:0] duty
);
    localparam int unsigned DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0]   DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] STEP_D    = PWM_BITS'(STEP);
    localparam logic [1:0]          DIR_OFF   = 2'b00;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DEAD} state_e;

    state_e              state, state_n;
    logic [1:0]          dir_n;
    logic [PWM_BITS-1:0] duty_n;
    logic [DEAD_W-1:0]   dead_cnt, dead_n;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS-1:0] ramped, drained;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            dir      <= DIR_OFF;
            duty     <= '0;
            dead_cnt <= '0;
        end else begin
            state    <= state_n;
            dir      <= dir_n;
            duty     <= duty_n;
            dead_cnt <= dead_n;
        end
    end

    // One ramp step toward the target, computed one bit wider so the step can never wrap.
    always_comb begin
        up_sum = {1'b0, duty} + {1'b0, STEP_D};
        if (duty < tgt_duty)
            ramped = (up_sum > {1'b0, tgt_duty}) ? tgt_duty : up_sum[PWM_BITS-1:0];
        else
            ramped = ((duty - tgt_duty) > STEP_D) ? duty - STEP_D : tgt_duty;
        drained = (duty > STEP_D) ? duty - STEP_D : '0;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        dir_n   = dir;
        duty_n  = duty;
        dead_n  = dead_cnt;
        if (tgt_dir == DIR_OFF) begin
            state_n = IDLE;
            dir_n   = DIR_OFF;
            duty_n  = '0;
            dead_n  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    dir_n   = tgt_dir;
                    state_n = RUN;
                end
                RUN: begin
                    if (tgt_dir != dir) state_n = DRAIN;
                    else if (tick)      duty_n  = ramped;
                end
                DRAIN: begin
                    if (tgt_dir == dir) begin
                        state_n = RUN;
                    end else if (duty == '0) begin
                        state_n = DEAD;
                        dir_n   = DIR_OFF;
                        dead_n  = DEAD_LOAD;
                    end else if (tick) begin
                        duty_n = drained;
                    end
                end
                DEAD: begin
                    // Hold is never shortened; the direction is picked up only at exit.
                    if (dead_cnt == '0) begin
                        state_n = RUN;
                        dir_n   = tgt_dir;
                        duty_n  = '0;
                    end else begin
                        dead_n = dead_cnt - DEAD_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

module motor_drive #(
    parameter int unsigned PWM_BITS    = 10,
    parameter int unsigned FAST_DUTY   = 768,
    parameter int unsigned SLOW_DUTY   = 512,
    parameter int unsigned RAMP_DIV    = 1000,
    parameter int unsigned RAMP_STEP   = 64,
    parameter int unsigned DEAD_CYCLES = 5000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          mode,
    output logic                left_pwm,
    output logic                right_pwm,
    output logic [1:0]          left_dir,
    output logic [1:0]          right_dir,
    output logic [PWM_BITS-1:0] left_duty,
    output logic [PWM_BITS-1:0] right_duty
);
    localparam int unsigned MAX_DUTY = (1 << PWM_BITS) - 1;
    localparam logic [PWM_BITS-1:0] FAST_D =
        PWM_BITS'((FAST_DUTY > MAX_DUTY) ? MAX_DUTY : FAST_DUTY);
    localparam logic [PWM_BITS-1:0] SLOW_D =
        PWM_BITS'((SLOW_DUTY > MAX_DUTY) ? MAX_DUTY : SLOW_DUTY);
    localparam int unsigned STEP_SAT = (RAMP_STEP > MAX_DUTY) ? MAX_DUTY : RAMP_STEP;
    localparam int unsigned DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [1:0] DIR_OFF = 2'b00;
    localparam logic [1:0] DIR_REV = 2'b01;
    localparam logic [1:0] DIR_FWD = 2'b10;

    typedef enum logic [2:0] {
        M_STOP, M_FORWARD, M_BACK, M_LEFT, M_RIGHT, M_STRONG_LEFT, M_STRONG_RIGHT, M_CODE7
    } mode_e;

    mode_e               mode_q;
    logic [1:0]          left_tdir, right_tdir;
    logic [PWM_BITS-1:0] left_tduty, right_tduty;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] left_applied, right_applied;

    always_ff @(posedge clk) begin
        if (reset) mode_q <= M_STOP;
        else       mode_q <= mode_e'(mode);
    end

    always_comb begin
        left_tdir   = DIR_OFF;
        right_tdir  = DIR_OFF;
        left_tduty  = '0;
        right_tduty = '0;
        unique case (mode_q)
            M_FORWARD:      begin left_tdir = DIR_FWD; left_tduty = FAST_D; right_tdir = DIR_FWD; right_tduty = FAST_D; end
            M_BACK:         begin left_tdir = DIR_REV; left_tduty = SLOW_D; right_tdir = DIR_REV; right_tduty = SLOW_D; end
            M_LEFT:         begin left_tdir = DIR_FWD; left_tduty = SLOW_D; right_tdir = DIR_FWD; right_tduty = FAST_D; end
            M_RIGHT:        begin left_tdir = DIR_FWD; left_tduty = FAST_D; right_tdir = DIR_FWD; right_tduty = SLOW_D; end
            M_STRONG_LEFT:  begin left_tdir = DIR_REV; left_tduty = SLOW_D; right_tdir = DIR_FWD; right_tduty = FAST_D; end
            M_STRONG_RIGHT: begin left_tdir = DIR_FWD; left_tduty = FAST_D; right_tdir = DIR_REV; right_tduty = SLOW_D; end
            default: ;
        endcase
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt       <= '0;
            cnt           <= '0;
            left_applied  <= '0;
            right_applied <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            cnt     <= cnt + PWM_BITS'(1);
            // Duty only changes at the period boundary so no period is ever truncated.
            if (cnt == '1) begin
                left_applied  <= left_duty;
                right_applied <= right_duty;
            end
        end
    end

    motor_drive_wheel #(.PWM_BITS(PWM_BITS), .STEP(STEP_SAT), .DEAD_CYCLES(DEAD_CYCLES)) u_left (
        .clk(clk), .reset(reset), .tick(tick), .tgt_dir(left_tdir), .tgt_duty(left_tduty),
        .dir(left_dir), .duty(left_duty)
    );

    motor_drive_wheel #(.PWM_BITS(PWM_BITS), .STEP(STEP_SAT), .DEAD_CYCLES(DEAD_CYCLES)) u_right (
        .clk(clk), .reset(reset), .tick(tick), .tgt_dir(right_tdir), .tgt_duty(right_tduty),
        .dir(right_dir), .duty(right_duty)
    );

    assign left_pwm  = (cnt < left_applied);
    assign right_pwm = (cnt < right_applied);
endmodule

// File: doc/motor_drive.md
MOTOR_DRIVE -- requirements
Module: motor_drive

Interface
REQ-001 Parameter PWM_BITS, default 10, sets the PWM counter width; the PWM period is 2^PWM_BITS clk cycles.
REQ-002 Parameter FAST_DUTY, default 768, is the duty for a fast wheel.
REQ-003 Parameter SLOW_DUTY, default 512, is the duty for a slow wheel.
REQ-004 Parameter RAMP_DIV, default 1000, is the number of clk cycles per ramp tick.
REQ-005 Parameter RAMP_STEP, default 64, is the maximum duty change per ramp tick.
REQ-006 Parameter DEAD_CYCLES, default 5000, is the zero-drive hold in clk cycles on a direction reversal.
REQ-007 Port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-008 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 Port mode, input, 3 bits: drive command from the line-tracker stage. Codes: 0 STOP, 1 FORWARD, 2 BACK, 3 LEFT, 4 RIGHT, 5 STRONG_LEFT, 6 STRONG_RIGHT.
REQ-010 Port left_pwm, output, 1 bit: left motor enable PWM.
REQ-011 Port right_pwm, output, 1 bit: right motor enable PWM.
REQ-012 Port left_dir, output, 2 bits: left H-bridge inputs; 2'b10 forward, 2'b01 reverse, 2'b00 off.
REQ-013 Port right_dir, output, 2 bits: right H-bridge inputs, same encoding as left_dir.
REQ-014 Port left_duty, output, PWM_BITS bits: applied left duty, for debug.
REQ-015 Port right_duty, output, PWM_BITS bits: applied right duty, for debug.

Function
REQ-016 Mode decode (target direction/duty per wheel) SHALL be:
- FORWARD: fwd FAST / fwd FAST.
- BACK: rev SLOW / rev SLOW.
- LEFT: fwd SLOW / fwd FAST.
- RIGHT: fwd FAST / fwd SLOW.
- STRONG_LEFT: rev SLOW / fwd FAST.
- STRONG_RIGHT: fwd FAST / rev SLOW.
- STOP and code 7: off, duty 0.
REQ-017 mode SHALL be registered once; the decode SHALL use the registered value, adding 1 cycle of latency.
REQ-018 Each wheel SHALL run an independent FSM with states IDLE, RUN, DRAIN and DEAD.
REQ-019 IDLE: dir 00, duty 0. A non-STOP target SHALL load the target dir and enter RUN.
REQ-020 RUN: on a ramp tick, duty SHALL move toward the target by min(RAMP_STEP, |target-duty|), never overshooting.
REQ-021 RUN with a target dir opposite to the current dir SHALL enter DRAIN; dir SHALL be held while draining.
REQ-022 DRAIN: duty SHALL ramp toward 0 at RAMP_STEP per tick. On reaching 0 it SHALL enter DEAD, set dir 00 and load the dead counter with DEAD_CYCLES-1.
REQ-023 DEAD: the counter SHALL decrement each cycle. At 0 the FSM SHALL load the current target dir and enter RUN with duty 0.
REQ-024 If the target dir reverts to the held dir during DRAIN, the FSM SHALL return to RUN without passing through DEAD.
REQ-025 A target change during DEAD SHALL NOT shorten the hold; the dir loaded on exit SHALL be the target at exit time.
REQ-026 STOP/code 7 SHALL force, from any state on the next cycle, duty 0, dir 00 and IDLE, with no ramp.
REQ-027 A shared ramp-tick divider SHALL free-run modulo RAMP_DIV and assert its tick for 1 cycle each wrap.
REQ-028 A free-running PWM_BITS counter cnt SHALL set pwm = (cnt < applied_duty).
REQ-029 applied_duty SHALL latch the FSM duty only when cnt wraps from all-ones to 0, giving glitch-free periods.
REQ-030 Duty 0 SHALL produce a constant-low pwm.
REQ-031 Duties SHALL saturate to 2^PWM_BITS-1; arithmetic SHALL be unsigned with no wrap-around.

Reset
REQ-032 While reset is high:
- both FSMs SHALL be IDLE;
- the registered mode SHALL be STOP;
- all counters and applied duties SHALL be 0;
- pwm outputs SHALL be 0;
- dir outputs SHALL be 00.
REQ-033 Reset asserted mid-ramp or mid-DEAD SHALL abort the operation; outputs SHALL equal reset values on the cycle after the sampling edge.

Verification
Bench parameters: PWM_BITS=4, FAST=12, SLOW=8, RAMP_DIV=2, RAMP_STEP=4, DEAD_CYCLES=3.
REQ-034 Reset, then FORWARD held -> left_dir=right_dir=10; duty 4, 8, 12 on successive ticks, then hold at 12; pwm high 12 of 16 cycles per period.
REQ-035 FORWARD at duty 12, then BACK -> dir held 10 while duty 8, 4, 0; then dir 00 for 3 cycles; then dir 01 and duty ramps 4, 8 and holds at 8.
REQ-036 RIGHT steady, then STRONG_RIGHT -> left stays fwd at 12 with no disturbance; right alone passes through DRAIN/DEAD to rev 8.
REQ-037 STOP issued mid-DEAD and mid-ramp -> one cycle later duty 0, dir 00, IDLE; pwm low from the next period boundary onward.
REQ-038 Duty change issued at cnt=5 -> pwm waveform unchanged until cnt wraps to 0; code 7 behaves identically to STOP.
REQ-039 Reset pulsed during DRAIN -> all outputs 0 on the next cycle; a later FORWARD ramps from 0.
